// File: rtl/prog_mem_loader.sv
// Writable program memory: registered 1-cycle fetch port plus a valid/ready
// loader that writes words from address 0, pads the rest with FILL and sums the loaded words.
module prog_mem_loader #(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 8,
  parameter int                DEPTH  = 256,
  parameter logic [DATA_W-1:0] FILL   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fetch_en,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_fetch_data,
  output logic              o_fetch_valid,
  input  logic              i_prog_start,
  input  logic [ADDR_W:0]   i_prog_len,
  input  logic              i_prog_valid,
  input  logic [DATA_W-1:0] i_prog_data,
  output logic              o_prog_ready,
  output logic              o_prog_busy,
  output logic              o_prog_done,
  output logic              o_prog_err,
  output logic [DATA_W-1:0] o_checksum
);

  localparam int              MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_done_next;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   w_ptr_inc;
  logic [DATA_W-1:0] r_checksum;
  logic              r_err;
  logic              r_done;
  logic              r_fetch_valid;
  logic              r_in_range;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_len_ok;
  logic              w_start_ok;
  logic              w_start_bad;
  logic              w_accept;
  logic              w_ready;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  assign w_len_ok    = (i_prog_len != '0) && (i_prog_len <= DEPTH_C);
  assign w_start_ok  = (r_state == S_IDLE) && i_prog_start && w_len_ok;
  assign w_start_bad = (r_state == S_IDLE) && i_prog_start && !w_len_ok;
  assign w_accept    = (r_state == S_LOAD) && i_prog_valid;
  assign w_ptr_inc   = r_ptr + ONE_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        if (w_accept && (w_ptr_inc == r_len)) begin
          // A full-depth program leaves nothing to pad.
          if (r_len == DEPTH_C) begin
            w_state_next = S_IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_state_next = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (r_ptr == LAST_C) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = 1'b0;
    w_we    = 1'b0;
    w_wdata = FILL;
    case (r_state)
      S_LOAD: begin
        w_ready = 1'b1;
        w_we    = i_prog_valid;
        w_wdata = i_prog_data;
      end
      S_PAD:   w_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_len         <= '0;
      r_checksum    <= '0;
      r_err         <= 1'b0;
      r_done        <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_in_range    <= 1'b0;
    end else begin
      r_done        <= w_done_next;
      r_fetch_valid <= i_fetch_en && (r_state == S_IDLE) && !i_prog_start;
      r_in_range    <= ({1'b0, i_fetch_addr} < DEPTH_C);
      if (w_start_ok) begin
        r_len      <= i_prog_len;
        r_ptr      <= '0;
        r_checksum <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_start_bad) r_err <= 1'b1;
        if (w_we) r_ptr <= w_ptr_inc;
        if (w_accept) r_checksum <= r_checksum + i_prog_data;
      end
    end
  end

  // Memory has no reset so it maps onto block RAM and survives an aborted load.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ptr[MEM_AW-1:0]] <= w_wdata;
    r_rd_data <= r_mem[i_fetch_addr[MEM_AW-1:0]];
  end

  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_data  = (r_fetch_valid && r_in_range) ? r_rd_data : FILL;
  assign o_prog_ready  = w_ready;
  assign o_prog_busy   = (r_state != S_IDLE);
  assign o_prog_done   = r_done;
  assign o_prog_err    = r_err;
  assign o_checksum    = r_checksum;

endmodule
